// File: rtl/router_req_scheduler.sv
// ----------------------------------------------------------------------------
// router_req_scheduler
//
// Purpose:
//   Round-robin arbiter and sequencer in front of a single router engine.
//   After the router reports that it has initialised, the block grants one
//   requester at a time. It pulses the router start with that requester's
//   source/destination, waits for a rising edge on router_done (or a
//   timeout), reports the completion and then sits idle for one gap cycle
//   before the next grant.
//
// Ports:
//   clk              in   single clock, rising edge
//   rst              in   asynchronous, active-high reset
//   req_valid        in   [NUM_REQ]         per-requester transfer request
//   req_ready        out  [NUM_REQ]         combinational grant, one-hot or 0
//   req_src          in   [NUM_REQ*ADDR_W]  packed source addresses
//   req_dst          in   [NUM_REQ*ADDR_W]  packed destination addresses
//   router_start_req out                    one-cycle start pulse
//   router_scr_addr  out  [ADDR_W]          source address (0 outside ISSUE)
//   router_dst_addr  out  [ADDR_W]          destination address (0 outside ISSUE)
//   router_done      in                     router idle level, rise = complete
//   cpl_valid        out                    one-cycle completion pulse
//   cpl_id           out  [2]               completed requester index (held)
//   cpl_timeout      out                    completion was a timeout
//   cpl_latency      out  [16]              WAIT cycles of the transfer (held)
//   xfer_count       out  [32]              successful completions, wrapping
//   busy             out                    state is not IDLE
// ----------------------------------------------------------------------------
module router_req_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_src,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dst,
    output logic                      router_start_req,
    output logic [ADDR_W-1:0]         router_scr_addr,
    output logic [ADDR_W-1:0]         router_dst_addr,
    input  logic                      router_done,
    output logic                      cpl_valid,
    output logic [1:0]                cpl_id,
    output logic                      cpl_timeout,
    output logic [15:0]               cpl_latency,
    output logic [31:0]               xfer_count,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // The timeout comparison is done at 32 bits so that a TIMEOUT beyond the
    // 16-bit counter range simply never fires instead of aliasing.
    localparam logic [31:0] TIMEOUT_32 = 32'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               state_q,       state_d;
    logic [IDX_W-1:0]     rr_ptr_q,      rr_ptr_d;
    logic [IDX_W-1:0]     idx_q,         idx_d;
    logic [ADDR_W-1:0]    src_q,         src_d;
    logic [ADDR_W-1:0]    dst_q,         dst_d;
    logic [15:0]          lat_cnt_q,     lat_cnt_d;
    logic                 done_q,        done_d;
    logic                 cpl_valid_q,   cpl_valid_d;
    logic [1:0]           cpl_id_q,      cpl_id_d;
    logic                 cpl_timeout_q, cpl_timeout_d;
    logic [15:0]          cpl_latency_q, cpl_latency_d;
    logic [31:0]          xfer_count_q,  xfer_count_d;
    logic                 busy_q,        busy_d;

    // ------------------------------------------------------------------------
    // Unpack the per-lane address buses
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] src_arr [NUM_REQ];
    logic [ADDR_W-1:0] dst_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign src_arr[gi] = req_src[gi*ADDR_W +: ADDR_W];
            assign dst_arr[gi] = req_dst[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin search starting at rr_ptr. Candidates are visited from the
    // farthest to the nearest so that the last hit (the nearest valid lane
    // at or after rr_ptr) wins without needing an early exit.
    // ------------------------------------------------------------------------
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;

    always_comb begin : arb
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Completion detection helpers
    // ------------------------------------------------------------------------
    logic        done_rise;
    logic [15:0] lat_inc;
    logic        lat_expired;

    assign done_rise   = router_done & ~done_q;
    // Count including the current WAIT cycle, saturating.
    assign lat_inc     = (lat_cnt_q == 16'hFFFF) ? lat_cnt_q : lat_cnt_q + 16'd1;
    assign lat_expired = ({16'd0, lat_inc} >= TIMEOUT_32);

    // ------------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        idx_d            = idx_q;
        src_d            = src_q;
        dst_d            = dst_q;
        lat_cnt_d        = lat_cnt_q;
        done_d           = router_done;
        cpl_valid_d      = 1'b0;
        cpl_id_d         = cpl_id_q;
        cpl_timeout_d    = cpl_timeout_q;
        cpl_latency_d    = cpl_latency_q;
        xfer_count_d     = xfer_count_q;
        req_ready        = '0;
        router_start_req = 1'b0;
        router_scr_addr  = '0;
        router_dst_addr  = '0;

        case (state_q)
            ST_INIT: begin
                // Router still initialising: no grants until it reports idle.
                if (router_done) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    idx_d   = grant_idx;
                    src_d   = src_arr[grant_idx];
                    dst_d   = dst_arr[grant_idx];
                    if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx + IDX_W'(1);
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                router_start_req = 1'b1;
                router_scr_addr  = src_q;
                router_dst_addr  = dst_q;
                lat_cnt_d        = '0;
                state_d          = ST_WAIT;
            end

            ST_WAIT: begin
                lat_cnt_d = lat_inc;
                // A real completion wins over a timeout landing on the same cycle.
                if (done_rise) begin
                    cpl_valid_d   = 1'b1;
                    cpl_timeout_d = 1'b0;
                    cpl_id_d      = 2'(idx_q);
                    cpl_latency_d = lat_inc;
                    xfer_count_d  = xfer_count_q + 32'd1;
                    state_d       = ST_GAP;
                end else if (lat_expired) begin
                    cpl_valid_d   = 1'b1;
                    cpl_timeout_d = 1'b1;
                    cpl_id_d      = 2'(idx_q);
                    cpl_latency_d = TIMEOUT_32[15:0];
                    state_d       = ST_GAP;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        // busy is registered from the next state so it tracks state_q exactly
        // while still reading 0 during reset.
        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT;
            rr_ptr_q      <= '0;
            idx_q         <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            lat_cnt_q     <= '0;
            done_q        <= 1'b0;
            cpl_valid_q   <= 1'b0;
            cpl_id_q      <= '0;
            cpl_timeout_q <= 1'b0;
            cpl_latency_q <= '0;
            xfer_count_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            idx_q         <= idx_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            lat_cnt_q     <= lat_cnt_d;
            done_q        <= done_d;
            cpl_valid_q   <= cpl_valid_d;
            cpl_id_q      <= cpl_id_d;
            cpl_timeout_q <= cpl_timeout_d;
            cpl_latency_q <= cpl_latency_d;
            xfer_count_q  <= xfer_count_d;
            busy_q        <= busy_d;
        end
    end

    assign cpl_valid   = cpl_valid_q;
    assign cpl_id      = cpl_id_q;
    assign cpl_timeout = cpl_timeout_q;
    assign cpl_latency = cpl_latency_q;
    assign xfer_count  = xfer_count_q;
    assign busy        = busy_q;

endmodule

// File: doc/router_req_scheduler.md
ROUTER_REQ_SCHEDULER -- requirements
Module: router_req_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (one per lane).
REQ-002 The block SHALL have parameter ADDR_W, default 10, width of the source and destination addresses.
REQ-003 The block SHALL have parameter TIMEOUT, default 4096, maximum number of WAIT cycles before a transfer is abandoned.
REQ-004 The block SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port req_valid  in  NUM_REQ  per-requester transfer request.
REQ-007 The block SHALL have port req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
REQ-008 The block SHALL have port req_src  in  NUM_REQ*ADDR_W  packed source addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port req_dst  in  NUM_REQ*ADDR_W  packed destination addresses, packed the same way as req_src.
REQ-010 The block SHALL have port router_start_req  out  1  one-cycle start pulse to the router.
REQ-011 The block SHALL have port router_scr_addr  out  ADDR_W  source address to the router.
REQ-012 The block SHALL have port router_dst_addr  out  ADDR_W  destination address to the router.
REQ-013 The block SHALL have port router_done  in  1  router idle/complete level; a rising edge marks completion.
REQ-014 The block SHALL have port cpl_valid  out  1  one-cycle completion pulse.
REQ-015 The block SHALL have port cpl_id  out  2  index of the completed requester.
REQ-016 The block SHALL have port cpl_timeout  out  1  qualifies cpl_valid; 1 means the transfer was abandoned on timeout.
REQ-017 The block SHALL have port cpl_latency  out  16  WAIT-cycle count of the completed transfer.
REQ-018 The block SHALL have port xfer_count  out  32  number of successful completions.
REQ-019 The block SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have the states INIT, IDLE, ISSUE, WAIT, GAP.
REQ-021 INIT SHALL move to IDLE on the first cycle router_done=1 (router initialisation complete) and SHALL grant nothing while in INIT.
REQ-022 In IDLE with any req_valid set, the block SHALL assert req_ready for exactly one requester combinationally in that same cycle.
REQ-023 The granted requester SHALL be the first valid requester found searching from rr_ptr upward with wrap-around.
REQ-024 On a grant the block SHALL latch that requester's src/dst and index, set rr_ptr to (grant+1) mod NUM_REQ, and go to ISSUE.
REQ-025 In IDLE with no req_valid set, the block SHALL stay in IDLE and leave rr_ptr unchanged.
REQ-026 In ISSUE the block SHALL drive router_start_req=1 with the latched addresses for exactly one cycle, then go to WAIT.
REQ-027 Outside ISSUE, router_start_req, router_scr_addr and router_dst_addr SHALL all be 0.
REQ-028 The block SHALL register router_done as done_q; done_rise = router_done & ~done_q.
REQ-029 The latency counter SHALL clear in ISSUE and increment each WAIT cycle, saturating at 16'hFFFF.
REQ-030 In WAIT, done_rise SHALL cause, on the next cycle: cpl_valid=1, cpl_timeout=0, cpl_id=latched index, cpl_latency=counter value including the current cycle, xfer_count+1 (wrapping at 2^32); the state SHALL go to GAP.
REQ-031 In WAIT, a router_done level held high without a rising edge SHALL NOT complete the transfer.
REQ-032 When the WAIT count reaches TIMEOUT without done_rise, the block SHALL pulse cpl_valid=1 with cpl_timeout=1 and cpl_latency=TIMEOUT, leave xfer_count unchanged, and go to GAP.
REQ-033 If done_rise and the timeout occur in the same cycle, done_rise SHALL take priority.
REQ-034 GAP SHALL last exactly one cycle, SHALL grant nothing, and SHALL return to IDLE; back-to-back transfers therefore have a minimum issue spacing of WAIT+3 cycles.
REQ-035 A requester dropping req_valid before it is granted SHALL lose its request without error.
REQ-036 cpl_id SHALL hold its value between pulses.
REQ-037 cpl_latency SHALL hold its value between pulses.

Reset
REQ-038 While rst=1 the block SHALL be in INIT with rr_ptr=0, done_q=0, the latency counter=0, and all outputs 0.
REQ-039 rst asserted mid-transfer SHALL abort the transfer immediately with no cpl_valid pulse, and the block SHALL re-enter INIT.
REQ-040 After rst is released the block SHALL wait for router_done=1 again before granting any requester.

Verification
REQ-041 Init: rst high for 4 cycles, router_done=0 for 10 further cycles, req_valid=4'b0001 -> req_ready stays 0 until router_done=1; then one grant follows.
REQ-042 Single transfer: requester 1 with src=10'h1, dst=10'h5; router drops done and raises it 20 cycles after the start pulse -> exactly one router_start_req pulse carrying 1/5; cpl_valid with cpl_id=1, cpl_latency=20, xfer_count=1.
REQ-043 Round-robin: req_valid=4'b1111 held for 36 transfers -> grant order 0,1,2,3,0,... repeated; xfer_count=36; each requester granted 9 times.
REQ-044 Timeout: TIMEOUT=64 and router_done never rises -> cpl_valid with cpl_timeout=1 and cpl_latency=64; xfer_count unchanged; the next request is still granted.
REQ-045 Reset in WAIT: assert rst 5 cycles after start -> no cpl_valid pulse; all outputs 0; the next grant waits for router_done=1.
REQ-046 Simultaneous events: done_rise on the cycle the counter reaches TIMEOUT -> cpl_timeout=0 and xfer_count increments.
